// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the register-bank write arbiter.
package reg_arb_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_WIDTH    = 16;

  // Bus ownership: either nobody owns the bank or exactly one requester does.
  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/reg_bank_arbiter_reg.sv
// Generic enabled register with asynchronous active-low reset.
// Used for bank storage and for every piece of arbiter state so that all
// flops in the block come from one cell type.
module reg_bank_arbiter_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable; reset value applies immediately on arst_n_in low.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      q <= RESET_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NUM_REQ burst writers through a round-robin arbiter.
// A requester wins the bank in IDLE, then owns it until a transfer with
// req_last set. Reads are combinational and independent of the arbiter.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | no owner; any req_valid triggers round-robin pick from rr_ptr
//  OWNED | grant_id owns the bank; its req_ready is high, writes on valid
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [AW-1:0]            rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);

  // One extra bit so pointer + offset never overflows before the wrap compare.
  localparam logic [GW:0] NREQ_W = (GW+1)'(NUM_REQ);

  logic             state_raw_q;
  logic             state_raw_d;
  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [GW-1:0]    rr_q;
  logic [GW-1:0]    rr_d;
  logic [GW-1:0]    grant_q;
  logic [GW-1:0]    grant_d;

  logic [GW:0]      cand;
  logic             win_found;
  logic [GW-1:0]    win_idx;
  logic [GW:0]      owner_inc;

  logic             xfer;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NUM_REGS-1:0] bank_we;
  logic [WIDTH-1:0] bank_q [NUM_REGS];

  assign state_q     = arb_state_e'(state_raw_q);
  assign state_raw_d = state_d;

  // Arbiter state lives in the shared register cell, always loaded.
  reg_bank_arbiter_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_state_reg (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .we        (1'b1),
    .d         (state_raw_d),
    .q         (state_raw_q)
  );

  reg_bank_arbiter_reg #(.WIDTH(GW), .RESET_VAL('0)) u_rr_reg (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .we        (1'b1),
    .d         (rr_d),
    .q         (rr_q)
  );

  reg_bank_arbiter_reg #(.WIDTH(GW), .RESET_VAL('0)) u_grant_reg (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .we        (1'b1),
    .d         (grant_d),
    .q         (grant_q)
  );

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (GW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!win_found && req_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
      end
    end
  end

  // Pointer value handed to the next arbitration when a burst ends.
  always_comb begin
    owner_inc = {1'b0, grant_q} + (GW+1)'(1);
    if (owner_inc >= NREQ_W) begin
      owner_inc = '0;
    end
  end

  // A transfer is the owner presenting valid while it holds the grant.
  assign xfer    = (state_q == OWNED) && req_valid[grant_q];
  assign wr_addr = req_addr[grant_q*AW +: AW];
  assign wr_data = req_data[grant_q*WIDTH +: WIDTH];

  // Next-state logic; grant_id returns to 0 whenever the bank is released.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = OWNED;
          grant_d = win_idx;
        end
      end
      OWNED: begin
        if (xfer && req_last[grant_q]) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = owner_inc[GW-1:0];
        end
      end
    endcase
  end

  // Ready is a pure function of ownership so the owner may stall freely.
  always_comb begin
    req_ready = '0;
    if (state_q == OWNED) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign busy     = (state_q == OWNED);
  assign grant_id = grant_q;

  // One bank register per index, each with a private write enable.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bank
    assign bank_we[g] = xfer && (wr_addr == AW'(g));

    reg_bank_arbiter_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_bank_reg (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .we        (bank_we[g]),
      .d         (wr_data),
      .q         (bank_q[g])
    );
  end

  assign rd_data = bank_q[rd_addr];

endmodule
